// File: rtl/trace_fifo_framer.sv
// -----------------------------------------------------------------------------
// trace_fifo_framer
//
// Pops 32-bit words from the read side of the trace width-converting FIFO and
// frames every four words (one 128-bit trace record) into a byte stream:
//   SYNC_BYTE, 16 data bytes (each word little-endian), XOR of the 16 data bytes
// The byte stream uses a valid/ready handshake toward the host link transmitter.
//
// Ports
//   clk         in   single clock, shared with the FIFO read side
//   rst_n       in   asynchronous active-low reset
//   en          in   permits starting a new frame (looked at only in IDLE)
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after a fifo_rd pulse
//   fifo_rd     out  FIFO read strobe, one-cycle pulse per word
//   tx_data     out  byte to the transmitter
//   tx_valid    out  tx_data is valid
//   tx_ready    in   transmitter accepts the byte this cycle
//   busy        out  high whenever the framer is not in IDLE
//   rec_cnt     out  count of completed frames, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module trace_fifo_framer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [31:0]      fifo_data,
    output logic             fifo_rd,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] rec_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_FETCH,
        S_WAIT,
        S_BYTE,
        S_CSUM
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_csum;
    logic [31:0]        r_word;
    logic [1:0]         r_w_idx;
    logic [1:0]         r_b_idx;
    logic [CNT_W-1:0]   r_rec_cnt;
    logic [7:0]         w_byte;
    logic               w_hs;

    assign w_hs    = tx_valid && tx_ready;
    assign busy    = (r_state != S_IDLE);
    assign rec_cnt = r_rec_cnt;

    // Little-endian byte select of the captured word.
    always_comb begin
        w_byte = r_word[7:0];
        case (r_b_idx)
            2'd0: w_byte = r_word[7:0];
            2'd1: w_byte = r_word[15:8];
            2'd2: w_byte = r_word[23:16];
            2'd3: w_byte = r_word[31:24];
            default: w_byte = r_word[7:0];
        endcase
    end

    // Next-state and handshake outputs. Indices only move on a handshake, so
    // tx_data stays put for as long as the transmitter holds tx_ready low.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        w_state_nxt = r_state;
        fifo_rd     = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (en && !fifo_empty) w_state_nxt = S_SYNC;
            end
            S_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                // An empty FIFO mid-frame just stalls here without popping.
                fifo_rd = !fifo_empty;
                if (!fifo_empty) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_BYTE;
            end
            S_BYTE: begin
                tx_valid = 1'b1;
                tx_data  = w_byte;
                if (tx_ready && (r_b_idx == 2'd3))
                    w_state_nxt = (r_w_idx == 2'd3) ? S_CSUM : S_FETCH;
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = r_csum;
                if (tx_ready) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the word buffer is a plain register (not an array), so it is
            // reset along with the rest of the datapath at no extra cost.
            r_state   <= S_IDLE;
            r_csum    <= 8'h00;
            r_word    <= 32'h0;
            r_w_idx   <= 2'd0;
            r_b_idx   <= 2'd0;
            r_rec_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    r_csum  <= 8'h00;
                    r_w_idx <= 2'd0;
                    r_b_idx <= 2'd0;
                end
                S_WAIT: begin
                    // FIFO read latency is one cycle: data from the FETCH pop is here now.
                    r_word  <= fifo_data;
                    r_b_idx <= 2'd0;
                end
                S_BYTE: begin
                    if (w_hs) begin
                        r_csum <= r_csum ^ w_byte;
                        if (r_b_idx != 2'd3)
                            r_b_idx <= r_b_idx + 2'd1;
                        else if (r_w_idx != 2'd3)
                            r_w_idx <= r_w_idx + 2'd1;
                    end
                end
                S_CSUM: begin
                    if (w_hs) r_rec_cnt <= r_rec_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_fifo_framer.sv
// -----------------------------------------------------------------------------
// tb_trace_fifo_framer
//
// Directed bench for trace_fifo_framer. A small FIFO model with one-cycle read
// latency feeds the DUT; a negedge monitor logs accepted bytes, frame start and
// end cycles, fifo_rd pulses and tx_data stability under backpressure.
// Inputs are driven 1 time unit after posedge, outputs sampled on negedge.
// -----------------------------------------------------------------------------
module tb_trace_fifo_framer;

    localparam int CNT_W = 2;

    typedef logic [31:0] words_t [4];
    typedef logic [7:0]  frame_t [18];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             fifo_empty;
    logic [31:0]      fifo_data = 32'h0;
    logic             fifo_rd;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] rec_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    trace_fifo_framer #(.SYNC_BYTE(8'hA5), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .rec_cnt    (rec_cnt)
    );

    // FIFO model: read data appears the cycle after fifo_rd.
    logic [31:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_data <= fifo_mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    logic [7:0] byte_q [$];
    int         start_q [$];
    int         end_q [$];
    int         rd_pulses = 0;
    int         valid_cycles = 0;
    int         unstable = 0;
    int         bad_rd = 0;
    bit         in_frame = 0;
    int         nbytes = 0;
    bit         hold_pend = 0;
    logic [7:0] hold_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 0;
            nbytes    = 0;
            hold_pend = 0;
        end else begin
            if (fifo_rd) rd_pulses++;
            if (fifo_rd && fifo_empty) bad_rd++;
            if (tx_valid) valid_cycles++;
            if (hold_pend && (!tx_valid || tx_data !== hold_data)) unstable++;
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid && !in_frame) begin
                in_frame = 1;
                start_q.push_back(cyc);
            end
            if (tx_valid && tx_ready) begin
                byte_q.push_back(tx_data);
                nbytes++;
                if (nbytes == 18) begin
                    end_q.push_back(cyc);
                    in_frame = 0;
                    nbytes   = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_logs();
        byte_q.delete();
        start_q.delete();
        end_q.delete();
        rd_pulses    = 0;
        valid_cycles = 0;
        unstable     = 0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (end_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        if (end_q.size() < n) begin
            n_total++;
            $display("FAIL %s_timeout: frames seen %0d required %0d", name, end_q.size(), n);
        end
    endtask

    function automatic void build_frame(input words_t w, output frame_t f);
        logic [7:0] cs;
        cs   = 8'h00;
        f[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                f[1 + 4*i + j] = w[i][8*j +: 8];
                cs = cs ^ w[i][8*j +: 8];
            end
        end
        f[17] = cs;
    endfunction

    // -1: match, -2: wrong length, else index of first differing byte.
    function automatic int first_diff(input frame_t exp);
        if (byte_q.size() != 18) return -2;
        for (int i = 0; i < 18; i++) if (byte_q[i] !== exp[i]) return i;
        return -1;
    endfunction

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        n_total++; if (fifo_rd !== 1'b0) $display("FAIL reset_fifo_rd: got %b required 0", fifo_rd); else n_pass++;
        n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b required 0", tx_valid); else n_pass++;
        n_total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h required 00", tx_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        n_total++; if (rec_cnt !== 2'd0) $display("FAIL reset_rec_cnt: got %0d required 0", rec_cnt); else n_pass++;
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_en_low();
        clear_logs();
        tx_ready = 1'b1;
        push_word(32'h00000001);
        push_word(32'h00000002);
        push_word(32'h00000004);
        push_word(32'h00000080);
        step(10);
        n_total++; if (rd_pulses !== 0) $display("FAIL en_low_fifo_rd: got %0d pulses required 0", rd_pulses); else n_pass++;
        n_total++; if (valid_cycles !== 0) $display("FAIL en_low_tx_valid: got %0d valid cycles required 0", valid_cycles); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL en_low_busy: got %b required 0", busy); else n_pass++;
    endtask

    task automatic test_basic_frame();
        frame_t exp;
        int     d;
        exp = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h04, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h87};
        en = 1'b1;
        wait_frames(1, 100, "basic");
        en = 1'b0;
        d = first_diff(exp);
        n_total++;
        if (d == -2) $display("FAIL basic_bytes: got %0d bytes required 18", byte_q.size());
        else if (d >= 0) $display("FAIL basic_bytes: byte %0d got %h required %h", d, byte_q[d], exp[d]);
        else n_pass++;
        n_total++; if (rec_cnt !== 2'd1) $display("FAIL basic_rec_cnt: got %0d required 1", rec_cnt); else n_pass++;
        n_total++; if (rd_pulses !== 4) $display("FAIL basic_fifo_rd: got %0d pulses required 4", rd_pulses); else n_pass++;
        n_total++;
        if (start_q.size() < 1 || end_q.size() < 1)
            $display("FAIL basic_cycles: got no frame bounds required 26 cycles");
        else if (end_q[0] - start_q[0] + 1 !== 26)
            $display("FAIL basic_cycles: got %0d required 26", end_q[0] - start_q[0] + 1);
        else n_pass++;
        step(2);
    endtask

    task automatic test_backpressure();
        frame_t exp;
        int     d;
        int     k;
        exp = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h04, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h87};
        clear_logs();
        push_word(32'h00000001);
        push_word(32'h00000002);
        push_word(32'h00000004);
        push_word(32'h00000080);
        en = 1'b1;
        tx_ready = 1'b1;
        k = 0;
        while (end_q.size() < 1 && k < 200) begin
            step(1);
            tx_ready = ~tx_ready;
            k++;
        end
        en = 1'b0;
        tx_ready = 1'b1;
        d = first_diff(exp);
        n_total++;
        if (d == -2) $display("FAIL bp_bytes: got %0d bytes required 18", byte_q.size());
        else if (d >= 0) $display("FAIL bp_bytes: byte %0d got %h required %h", d, byte_q[d], exp[d]);
        else n_pass++;
        n_total++; if (unstable !== 0) $display("FAIL bp_stable: got %0d unstable cycles required 0", unstable); else n_pass++;
        n_total++; if (rec_cnt !== 2'd2) $display("FAIL bp_rec_cnt: got %0d required 2", rec_cnt); else n_pass++;
        step(2);
    endtask

    task automatic test_underflow();
        words_t w;
        frame_t exp;
        int     d;
        w = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        build_frame(w, exp);
        clear_logs();
        push_word(w[0]);
        push_word(w[1]);
        en = 1'b1;
        step(40);
        n_total++; if (busy !== 1'b1) $display("FAIL uf_busy: got %b required 1", busy); else n_pass++;
        n_total++; if (tx_valid !== 1'b0) $display("FAIL uf_tx_valid: got %b required 0", tx_valid); else n_pass++;
        n_total++; if (fifo_rd !== 1'b0) $display("FAIL uf_fifo_rd: got %b required 0", fifo_rd); else n_pass++;
        n_total++; if (rd_pulses !== 2) $display("FAIL uf_pulses: got %0d required 2", rd_pulses); else n_pass++;
        step(10);
        push_word(w[2]);
        push_word(w[3]);
        wait_frames(1, 100, "uf");
        en = 1'b0;
        d = first_diff(exp);
        n_total++;
        if (d == -2) $display("FAIL uf_bytes: got %0d bytes required 18", byte_q.size());
        else if (d >= 0) $display("FAIL uf_bytes: byte %0d got %h required %h", d, byte_q[d], exp[d]);
        else n_pass++;
        n_total++; if (bad_rd !== 0) $display("FAIL uf_rd_when_empty: got %0d required 0", bad_rd); else n_pass++;
        step(2);
    endtask

    task automatic test_async_reset();
        words_t w;
        frame_t exp;
        int     d;
        int     k;
        clear_logs();
        push_word(32'hDEADBEEF);
        push_word(32'h01234567);
        push_word(32'h89ABCDEF);
        push_word(32'hCAFEF00D);
        en = 1'b1;
        k = 0;
        // Sync + word 0 + word 1 + first byte of word 2.
        while (byte_q.size() < 10 && k < 100) begin
            step(1);
            k++;
        end
        #2;
        n_total++; if (tx_valid !== 1'b1 || busy !== 1'b1) $display("FAIL ar_pre: got valid %b busy %b required 1 1", tx_valid, busy); else n_pass++;
        n_total++; if (rec_cnt !== 2'd3) $display("FAIL ar_pre_cnt: got %0d required 3", rec_cnt); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (tx_valid !== 1'b0) $display("FAIL ar_tx_valid: got %b required 0", tx_valid); else n_pass++;
        n_total++; if (fifo_rd !== 1'b0) $display("FAIL ar_fifo_rd: got %b required 0", fifo_rd); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b required 0", busy); else n_pass++;
        n_total++; if (rec_cnt !== 2'd0) $display("FAIL ar_rec_cnt: got %0d required 0", rec_cnt); else n_pass++;
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        // Three words were popped before reset; one remains in the FIFO.
        clear_logs();
        push_word(32'h000000FF);
        push_word(32'h10000001);
        push_word(32'h0F0F0F0F);
        w = '{32'hCAFEF00D, 32'h000000FF, 32'h10000001, 32'h0F0F0F0F};
        build_frame(w, exp);
        en = 1'b1;
        wait_frames(1, 100, "ar");
        en = 1'b0;
        n_total++; if (byte_q.size() < 1 || byte_q[0] !== 8'hA5) $display("FAIL ar_first_sync: got %h required a5", (byte_q.size() > 0) ? byte_q[0] : 8'hxx); else n_pass++;
        d = first_diff(exp);
        n_total++;
        if (d == -2) $display("FAIL ar_bytes: got %0d bytes required 18", byte_q.size());
        else if (d >= 0) $display("FAIL ar_bytes: byte %0d got %h required %h", d, byte_q[d], exp[d]);
        else n_pass++;
        n_total++; if (rec_cnt !== 2'd1) $display("FAIL ar_rec_cnt_after: got %0d required 1", rec_cnt); else n_pass++;
        step(2);
    endtask

    task automatic test_en_drop();
        words_t w;
        frame_t exp;
        int     d;
        int     k;
        logic [31:0] more [4];
        w    = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978};
        more = '{32'hA1B2C3D4, 32'hE5F60718, 32'h293A4B5C, 32'h6D7E8F90};
        build_frame(w, exp);
        clear_logs();
        for (int i = 0; i < 4; i++) push_word(w[i]);
        for (int i = 0; i < 4; i++) push_word(more[i]);
        en = 1'b1;
        k = 0;
        while (byte_q.size() < 1 && k < 50) begin
            step(1);
            k++;
        end
        en = 1'b0;
        wait_frames(1, 100, "en_drop");
        step(40);
        d = first_diff(exp);
        n_total++;
        if (d == -2) $display("FAIL en_drop_bytes: got %0d bytes required 18", byte_q.size());
        else if (d >= 0) $display("FAIL en_drop_bytes: byte %0d got %h required %h", d, byte_q[d], exp[d]);
        else n_pass++;
        n_total++; if (start_q.size() !== 1) $display("FAIL en_drop_frames: got %0d frame starts required 1", start_q.size()); else n_pass++;
        n_total++; if (rd_pulses !== 4) $display("FAIL en_drop_pulses: got %0d required 4", rd_pulses); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL en_drop_busy: got %b required 0", busy); else n_pass++;
        n_total++; if (rec_cnt !== 2'd2) $display("FAIL en_drop_rec_cnt: got %0d required 2", rec_cnt); else n_pass++;
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        n_total++; if (rec_cnt !== 2'd0) $display("FAIL wrap_reset_cnt: got %0d required 0", rec_cnt); else n_pass++;
        // Four words remain from the previous test; top up to five records.
        for (int i = 0; i < 16; i++) push_word(32'h01000000 * (i + 1) + 32'h00000100 * i + 32'h5);
        clear_logs();
        en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            wait_frames(f + 1, 100, "wrap");
            n_total++; if (rec_cnt !== exp_cnt[f]) $display("FAIL wrap_cnt_%0d: got %0d required %0d", f, rec_cnt, exp_cnt[f]); else n_pass++;
        end
        en = 1'b0;
        for (int f = 1; f < 5; f++) begin
            n_total++;
            if (start_q.size() <= f) $display("FAIL wrap_period_%0d: got %0d frames required 5", f, start_q.size());
            else if (start_q[f] - start_q[f-1] !== 27) $display("FAIL wrap_period_%0d: got %0d required 27", f, start_q[f] - start_q[f-1]);
            else n_pass++;
        end
        n_total++; if (byte_q.size() !== 90) $display("FAIL wrap_bytes: got %0d required 90", byte_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_en_low();
        test_basic_frame();
        test_backpressure();
        test_underflow();
        test_async_reset();
        test_en_drop();
        test_counter_wrap();
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
